sum_range_solver: RTL

Inverse of the range-sum unit: given a start value and a target sum, iteratively accumulates start, start+1, … and reports the smallest stop value whose running sum reaches or exceeds the target. Sits beside the range-sum block in the `sum100` area. Lets a stop value be recovered from a start value and sum, and supports round-trip checks against the forward summer. Uses a valid/ready request on the input side and a valid/ready result on the output side. It adds one term per clock.

---
 rtl/sum_pkg.sv | 31 +++
 rtl/sum_range_solver_if.sv | 35 +++
 rtl/sum_range_step.sv | 31 +++
 rtl/sum_range_solver.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// ============================================================================
// Module      : sum_pkg
// Description : Shared definitions for the sum100 range-sum / range-solver
//               blocks: default operand widths, solver state encoding and
//               the max-term helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_pkg;

    // Default operand widths; 0..255 summed is 32640, which fits in 17 bits.
    localparam int unsigned VAL_W_DEF = 8;
    localparam int unsigned SUM_W_DEF = 17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Largest term representable in a w-bit operand.
    function automatic int unsigned max_term(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned C_MAX_TERM = max_term(VAL_W_DEF);

endpackage

`default_nettype wire

// File: rtl/sum_range_solver_if.sv
// ============================================================================
// Module      : sum_range_solver_if
// Description : Request/result bus of the range solver. The master issues
//               start/target requests and consumes stop/found/exact results;
//               the slave is the solver itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_range_solver_if #(
    parameter int unsigned VAL_W = 8,
    parameter int unsigned SUM_W = 17
);
    logic             in_valid;
    logic             in_ready;
    logic [VAL_W-1:0] start;
    logic [SUM_W-1:0] target;
    logic             out_valid;
    logic             out_ready;
    logic [VAL_W-1:0] stop;
    logic             found;
    logic             exact;

    modport master (
        output in_valid, start, target, out_ready,
        input  in_ready, out_valid, stop, found, exact
    );

    modport slave (
        input  in_valid, start, target, out_ready,
        output in_ready, out_valid, stop, found, exact
    );
endinterface

`default_nettype wire

// File: rtl/sum_range_step.sv
// ============================================================================
// Module      : sum_range_step
// Description : One accumulation step of the range solver (combinational):
//               adds the current term and compares against the target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_range_step #(
    parameter int unsigned      VAL_W    = 8,
    parameter int unsigned      SUM_W    = 17,
    parameter logic [VAL_W-1:0] MAX_TERM = '1
) (
    input  wire logic [SUM_W-1:0] acc,
    input  wire logic [VAL_W-1:0] k,
    input  wire logic [SUM_W-1:0] target,
    output logic      [SUM_W-1:0] acc_next,
    output logic                  ge,
    output logic                  eq,
    output logic                  last
);

    // SUM_W is sized so the full 0..MAX_TERM series cannot wrap.
    assign acc_next = acc + SUM_W'(k);
    assign ge       = (acc_next >= target);
    assign eq       = (acc_next == target);
    assign last     = (k == MAX_TERM);

endmodule

`default_nettype wire

// File: rtl/sum_range_solver.sv
// ============================================================================
// Module      : sum_range_solver
// Description : Finds the smallest stop >= start whose running sum
//               start+(start+1)+..+stop reaches a target, one term per clock.
//               Optional term counter output when SUM_RANGE_SOLVER_ITER_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_range_solver
    import sum_pkg::*;
#(
    parameter int unsigned VAL_W = VAL_W_DEF,
    parameter int unsigned SUM_W = SUM_W_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sum_range_solver_if.slave   bus
`ifdef SUM_RANGE_SOLVER_ITER_EN
    ,
    output logic [VAL_W:0]      iter_cnt
`endif
);

    localparam logic [VAL_W-1:0] c_max_term = VAL_W'(max_term(VAL_W));

    state_t           r_state;
    logic [VAL_W-1:0] r_k;
    logic [SUM_W-1:0] r_target;
    logic [SUM_W-1:0] r_acc;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [VAL_W-1:0] r_stop;
    logic             r_found;
    logic             r_exact;
`ifdef SUM_RANGE_SOLVER_ITER_EN
    logic [VAL_W:0]   r_iter_cnt;
`endif

    logic [SUM_W-1:0] w_acc_next;
    logic             w_ge;
    logic             w_eq;
    logic             w_last;

    sum_range_step #(
        .VAL_W    (VAL_W),
        .SUM_W    (SUM_W),
        .MAX_TERM (c_max_term)
    ) u_step (
        .acc      (r_acc),
        .k        (r_k),
        .target   (r_target),
        .acc_next (w_acc_next),
        .ge       (w_ge),
        .eq       (w_eq),
        .last     (w_last)
    );

    // Solver FSM: accept in IDLE, add one term per RUN cycle, hold result in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_target    <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_stop      <= '0;
            r_found     <= 1'b0;
            r_exact     <= 1'b0;
`ifdef SUM_RANGE_SOLVER_ITER_EN
            r_iter_cnt  <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_k        <= bus.start;
                        r_target   <= bus.target;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
`ifdef SUM_RANGE_SOLVER_ITER_EN
                        r_iter_cnt <= '0;
`endif
                    end
                end
                S_RUN: begin
`ifdef SUM_RANGE_SOLVER_ITER_EN
                    r_iter_cnt <= r_iter_cnt + 1'b1;
`endif
                    if (w_ge) begin
                        r_stop      <= r_k;
                        r_found     <= 1'b1;
                        r_exact     <= w_eq;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_last) begin
                        // Ran out of terms without reaching the target.
                        r_stop      <= r_k;
                        r_found     <= 1'b0;
                        r_exact     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_k   <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.stop      = r_stop;
    assign bus.found     = r_found;
    assign bus.exact     = r_exact;
`ifdef SUM_RANGE_SOLVER_ITER_EN
    assign iter_cnt      = r_iter_cnt;
`endif

endmodule

`default_nettype wire
